// File: rtl/servo_bank_controller.sv
// Multi-channel 50 Hz servo PWM bank driven by PS/2 set-2 scan codes, with per-frame double-buffered positions.
// Optional macro SERVO_SLEW_EN limits how far each shadow position may move per frame.
module servo_bank_controller #(
  parameter int CHANNELS = 4,
  parameter int CLK_HZ   = 25000000,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int FRAME_US = 20000,
  parameter int STEP_US  = 10,
  parameter int SLEW_US  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          scan,
  input  logic                scan_valid,
  output logic [CHANNELS-1:0] servo_pwm,
  output logic [2:0]          sel_ch,
  output logic                frame_start
);

  localparam int SPAN = MAX_US - MIN_US;
  localparam int CTR  = SPAN / 2;
  localparam int DIV  = CLK_HZ / 1000000;
  localparam int PW   = (SPAN > 0) ? $clog2(SPAN + 1) : 1;
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int UW   = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  localparam logic [31:0]   SPAN_U = 32'(SPAN);
  localparam logic [31:0]   STEP_U = 32'(STEP_US);
  localparam logic [31:0]   SLEW_U = 32'(SLEW_US);
  localparam logic [31:0]   MIN_U  = 32'(MIN_US);
  localparam logic [31:0]   CH_U   = 32'(CHANNELS);
  localparam logic [PW-1:0] CTR_P  = PW'(CTR);

  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_EXT} dec_state_t;

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] p);
    logic [31:0] s;
    s = 32'(p) + STEP_U;
    return (s > SPAN_U) ? PW'(SPAN_U) : PW'(s);
  endfunction

  function automatic logic [PW-1:0] sat_dec(input logic [PW-1:0] p);
    return (32'(p) >= STEP_U) ? PW'(32'(p) - STEP_U) : '0;
  endfunction

  function automatic logic [PW-1:0] slew_step(input logic [PW-1:0] sh, input logic [PW-1:0] cmd);
    logic [31:0] s;
    logic [31:0] c;
    s = 32'(sh);
    c = 32'(cmd);
    if (c > s) return (c - s <= SLEW_U) ? cmd : PW'(s + SLEW_U);
    else       return (s - c <= SLEW_U) ? cmd : PW'(s - SLEW_U);
  endfunction

  dec_state_t          state_q, state_d;
  logic [DW-1:0]       presc_q, presc_d;
  logic [UW-1:0]       us_cnt_q, us_cnt_d;
  logic [2:0]          sel_ch_q, sel_ch_d;
  logic [PW-1:0]       pos_cmd_q [CHANNELS];
  logic [PW-1:0]       pos_cmd_d [CHANNELS];
  logic [PW-1:0]       pos_sh_q  [CHANNELS];
  logic [PW-1:0]       pos_sh_d  [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                frame_start_q;

  logic       us_tick, wrap;
  logic       dig_hit, sel_ld;
  logic [2:0] dig_idx;
  logic       cmd_inc, cmd_dec, cmd_ctr;

  assign us_tick = (presc_q == DW'(DIV - 1));
  assign wrap    = us_tick && (us_cnt_q == UW'(FRAME_US - 1));
  assign presc_d = us_tick ? '0 : presc_q + DW'(1);
  assign us_cnt_d = !us_tick ? us_cnt_q : (wrap ? '0 : us_cnt_q + UW'(1));

  // Digits beyond the last channel are treated like any unmapped key.
  assign sel_ld   = dig_hit && (32'(dig_idx) < CH_U);
  assign sel_ch_d = sel_ld ? dig_idx : sel_ch_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan == 8'hF0)      state_d = ST_BREAK;
          else if (scan == 8'hE0) state_d = ST_EXT;
        end
        ST_BREAK: state_d = ST_IDLE;
        ST_EXT:   state_d = (scan == 8'hF0) ? ST_BREAK : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dig_hit = 1'b0;
    dig_idx = '0;
    cmd_inc = 1'b0;
    cmd_dec = 1'b0;
    cmd_ctr = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          case (scan)
            8'h16: begin dig_hit = 1'b1; dig_idx = 3'd0; end
            8'h1E: begin dig_hit = 1'b1; dig_idx = 3'd1; end
            8'h26: begin dig_hit = 1'b1; dig_idx = 3'd2; end
            8'h25: begin dig_hit = 1'b1; dig_idx = 3'd3; end
            8'h2E: begin dig_hit = 1'b1; dig_idx = 3'd4; end
            8'h36: begin dig_hit = 1'b1; dig_idx = 3'd5; end
            8'h3D: begin dig_hit = 1'b1; dig_idx = 3'd6; end
            8'h3E: begin dig_hit = 1'b1; dig_idx = 3'd7; end
            8'h1C: cmd_dec = 1'b1;
            8'h23: cmd_inc = 1'b1;
            8'h21: cmd_ctr = 1'b1;
            default: ;
          endcase
        end
        ST_EXT: begin
          case (scan)
            8'h6B: cmd_dec = 1'b1;
            8'h74: cmd_inc = 1'b1;
            8'h75: cmd_ctr = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Shadow loads from the pre-command value, so a command landing on the wrap waits a frame.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pos_cmd_d[i] = pos_cmd_q[i];
      if (sel_ch_q == 3'(i)) begin
        if (cmd_inc)      pos_cmd_d[i] = sat_inc(pos_cmd_q[i]);
        else if (cmd_dec) pos_cmd_d[i] = sat_dec(pos_cmd_q[i]);
        else if (cmd_ctr) pos_cmd_d[i] = CTR_P;
      end
      pos_sh_d[i] = pos_sh_q[i];
      if (wrap) begin
`ifdef SERVO_SLEW_EN
        pos_sh_d[i] = slew_step(pos_sh_q[i], pos_cmd_q[i]);
`else
        pos_sh_d[i] = pos_cmd_q[i];
`endif
      end
      pwm_d[i] = (32'(us_cnt_q) < MIN_U + 32'(pos_sh_q[i]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q       <= '0;
      us_cnt_q      <= '0;
      sel_ch_q      <= '0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        pos_cmd_q[i] <= CTR_P;
        pos_sh_q[i]  <= CTR_P;
      end
    end else begin
      presc_q       <= presc_d;
      us_cnt_q      <= us_cnt_d;
      sel_ch_q      <= sel_ch_d;
      pwm_q         <= pwm_d;
      frame_start_q <= wrap;
      for (int i = 0; i < CHANNELS; i++) begin
        pos_cmd_q[i] <= pos_cmd_d[i];
        pos_sh_q[i]  <= pos_sh_d[i];
      end
    end
  end

  assign servo_pwm   = pwm_q;
  assign sel_ch      = sel_ch_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_bank_controller.sv
// Scoreboard bench for servo_bank_controller using a scaled timebase (2 clk/us, 300 us frame).
module tb_servo_bank_controller;

  localparam int CH        = 4;
  localparam int CLK_HZ    = 2000000;
  localparam int MIN_US    = 100;
  localparam int MAX_US    = 200;
  localparam int FRAME_US  = 300;
  localparam int STEP_US   = 2;
  localparam int SLEW_US   = 4;
  localparam int DIV       = CLK_HZ / 1000000;
  localparam int SPAN      = MAX_US - MIN_US;
  localparam int CTR       = SPAN / 2;
  localparam int FRAME_CLK = FRAME_US * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    scan = 8'h00;
  logic          scan_valid = 1'b0;
  logic [CH-1:0] servo_pwm;
  logic [2:0]    sel_ch;
  logic          frame_start;

  servo_bank_controller #(
    .CHANNELS(CH), .CLK_HZ(CLK_HZ), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .FRAME_US(FRAME_US), .STEP_US(STEP_US), .SLEW_US(SLEW_US)
  ) dut (
    .clk(clk), .reset(reset), .scan(scan), .scan_valid(scan_valid),
    .servo_pwm(servo_pwm), .sel_ch(sel_ch), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_pos[CH];
  int hi_cnt[CH];
  int last_w[CH];
  int per_cnt = 0;
  int last_per = 0;
  int frames_seen = 0;
  int consumed = 0;

  // Per-frame high-time monitor; a frame runs from one frame_start cycle to the next.
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
      per_cnt = 0;
    end else begin
      if (frame_start) begin
        for (int c = 0; c < CH; c++) begin
          last_w[c] = hi_cnt[c];
          hi_cnt[c] = 0;
        end
        last_per = per_cnt;
        per_cnt = 0;
        frames_seen++;
      end
      for (int c = 0; c < CH; c++) if (servo_pwm[c]) hi_cnt[c]++;
      per_cnt++;
    end
  end

  function automatic int w_clk(input int p);
    return (MIN_US + p) * DIV;
  endfunction

  task automatic push_frame();
    for (int c = 0; c < CH; c++) exp_q.push_back(w_clk(exp_pos[c]));
  endtask

  task automatic wait_frame(output bit ok);
    int n = 0;
    while (frames_seen <= consumed && n < 2 * FRAME_CLK + 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (frames_seen > consumed);
    consumed = frames_seen;
  endtask

  task automatic send_seq(input logic [7:0] codes[$]);
    for (int k = 0; k < codes.size(); k++) begin
      @(negedge clk);
      scan = codes[k];
      scan_valid = 1'b1;
    end
    @(negedge clk);
    scan_valid = 1'b0;
    #1;
  endtask

  task automatic send_rep(input logic [7:0] code, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      scan = code;
      scan_valid = 1'b1;
    end
    @(negedge clk);
    scan_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    int e;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (servo_pwm !== '0) begin errors++; $display("FAIL reset_pwm got=%h want=0", servo_pwm); end
    checks++; if (sel_ch !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d want=0", sel_ch); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    for (int c = 0; c < CH; c++) exp_pos[c] = CTR;
    push_frame();
    push_frame();
    @(negedge clk);
    reset = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_frame%0d timeout got=none want=frame_start", f); end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (last_w[c] !== e) begin errors++; $display("FAIL reset_width f%0d ch%0d got=%0d want=%0d", f, c, last_w[c], e); end
      end
    end
    checks++; if (last_per !== FRAME_CLK) begin errors++; $display("FAIL frame_period got=%0d want=%0d", last_per, FRAME_CLK); end
    checks++; if (sel_ch !== 3'd0) begin errors++; $display("FAIL reset_sel_after got=%0d want=0", sel_ch); end
  endtask

  task automatic test_select_inc();
    bit ok;
    int e;
    logic [7:0] seq[$];
    repeat (50) @(negedge clk);
    seq = '{8'h1E, 8'h23, 8'h23, 8'h23};
    send_seq(seq);
    checks++; if (sel_ch !== 3'd1) begin errors++; $display("FAIL select_ch1 got=%0d want=1", sel_ch); end
    push_frame();
    exp_pos[1] = CTR + 3 * STEP_US;
    push_frame();
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL select_frame%0d timeout got=none want=frame_start", f); end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (last_w[c] !== e) begin errors++; $display("FAIL select_width f%0d ch%0d got=%0d want=%0d", f, c, last_w[c], e); end
      end
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int e;
    logic [7:0] seq[$];
    seq = '{8'h16};
    send_seq(seq);
    send_rep(8'h23, 60);
    checks++; if (sel_ch !== 3'd0) begin errors++; $display("FAIL sat_sel got=%0d want=0", sel_ch); end
    push_frame();
    exp_pos[0] = SPAN;
    push_frame();
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sat_hi_frame%0d timeout got=none want=frame_start", f); end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (last_w[c] !== e) begin errors++; $display("FAIL sat_hi_width f%0d ch%0d got=%0d want=%0d", f, c, last_w[c], e); end
      end
    end
    send_rep(8'h1C, 110);
    push_frame();
    exp_pos[0] = 0;
    push_frame();
    seq = '{8'h00};
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sat_lo_frame%0d timeout got=none want=frame_start", f); end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (last_w[c] !== e) begin errors++; $display("FAIL sat_lo_width f%0d ch%0d got=%0d want=%0d", f, c, last_w[c], e); end
      end
    end
    seq = '{8'h21};
    send_seq(seq);
    push_frame();
    exp_pos[0] = CTR;
    push_frame();
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL centre_frame%0d timeout got=none want=frame_start", f); end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (last_w[c] !== e) begin errors++; $display("FAIL centre_width f%0d ch%0d got=%0d want=%0d", f, c, last_w[c], e); end
      end
    end
  endtask

  task automatic test_break_ext();
    bit ok;
    int e;
    logic [7:0] seq[$];
    seq = '{8'hF0, 8'h23, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h74, 8'h2E, 8'h3E};
    send_seq(seq);
    checks++; if (sel_ch !== 3'd0) begin errors++; $display("FAIL ext_sel got=%0d want=0", sel_ch); end
    push_frame();
    exp_pos[0] = CTR + STEP_US;
    push_frame();
    for (int f = 0; f < 2; f++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ext_frame%0d timeout got=none want=frame_start", f); end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (last_w[c] !== e) begin errors++; $display("FAIL ext_width f%0d ch%0d got=%0d want=%0d", f, c, last_w[c], e); end
      end
    end
  endtask

  task automatic test_wrap_collision();
    bit ok;
    int e;
    // Strobe during the last cycle of the frame, i.e. the cycle the counter wraps.
    repeat (FRAME_CLK - 1) @(negedge clk);
    scan = 8'h23;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    push_frame();
    push_frame();
    exp_pos[0] = exp_pos[0] + STEP_US;
    push_frame();
    for (int f = 0; f < 3; f++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_frame%0d timeout got=none want=frame_start", f); end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (last_w[c] !== e) begin errors++; $display("FAIL wrap_width f%0d ch%0d got=%0d want=%0d", f, c, last_w[c], e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e;
    logic [7:0] seq[$];
    seq = '{8'h26};
    send_seq(seq);
    repeat (40) @(negedge clk);
    #1;
    checks++; if (servo_pwm !== {CH{1'b1}}) begin errors++; $display("FAIL mid_pulse_high got=%h want=%h", servo_pwm, {CH{1'b1}}); end
    checks++; if (sel_ch !== 3'd2) begin errors++; $display("FAIL mid_sel got=%0d want=2", sel_ch); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (servo_pwm !== '0) begin errors++; $display("FAIL mid_reset_pwm got=%h want=0", servo_pwm); end
    checks++; if (sel_ch !== 3'd0) begin errors++; $display("FAIL mid_reset_sel got=%0d want=0", sel_ch); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < CH; c++) exp_pos[c] = CTR;
    push_frame();
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_frame timeout got=none want=frame_start"); end
    for (int c = 0; c < CH; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (last_w[c] !== e) begin errors++; $display("FAIL mid_width ch%0d got=%0d want=%0d", c, last_w[c], e); end
    end
  endtask

  task automatic test_slew();
    bit ok;
    int e;
    send_rep(8'h23, 10);
    push_frame();
    for (int f = 0; f < 6; f++) begin
      exp_pos[0] = (exp_pos[0] + SLEW_US > CTR + 10 * STEP_US) ? CTR + 10 * STEP_US : exp_pos[0] + SLEW_US;
      push_frame();
    end
    for (int f = 0; f < 7; f++) begin
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL slew_frame%0d timeout got=none want=frame_start", f); end
      for (int c = 0; c < CH; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (last_w[c] !== e) begin errors++; $display("FAIL slew_width f%0d ch%0d got=%0d want=%0d", f, c, last_w[c], e); end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef SERVO_SLEW_EN
    test_slew();
`else
    test_select_inc();
    test_saturate();
    test_break_ext();
    test_wrap_collision();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
